spi_master_engine: RTL and testbench
====================================

Name: spi_master_engine

Overview:
- Parametrised SPI mode-0 master transfer engine. Successor to the fixed single-flash/TF SPI core.
- Adds N chip selects, a programmable clock divider in place of the fast/slow select, a configurable buffer depth, wait-and-read with a poll limit, and abort.
- Sits between the register/buffer logic and the SPIMux output stage. Drives an external TX-read/RX-write buffer port.

Parameters:
- CS_COUNT, 2, number of chip-select outputs (≥1)
- BUF_DEPTH, 512, bytes per buffer (power of 2); Len and address width AW = clog2(BUF_DEPTH)
- DIV_W, 8, width of the clock-divider field
- WAIT_LIMIT, 4096, max 0xFF bytes discarded in wait-and-read before timeout

Ports:
- Clk  in  1  transfer clock
- Reset  in  1  asynchronous, active-high
- Start  in  1  one-cycle pulse; begins a transfer; ignored while Busy
- Abort  in  1  one-cycle pulse; ends the transfer at the next byte boundary
- Mode  in  2  0=write, 1=read, 2=exchange, 3=wait-and-read; latched at Start
- Len  in  AW  byte count minus 1; latched at Start
- ClkDiv  in  DIV_W  SCK half-period = ClkDiv+1 Clk cycles; latched at Start
- CsSel  in  clog2(CS_COUNT) (min 1)  device select
- CsAssert  in  1  level; drives the selected /CS low
- TxAddr  out  AW  TX buffer read address; buffer has synchronous read, 1-cycle latency
- TxData  in  8  TX buffer read data
- RxWe  out  1  RX buffer write strobe, 1 cycle
- RxAddr  out  AW  RX write address
- RxData  out  8  RX write data
- SpiDo  out  1  MOSI
- SpiDi  in  1  MISO
- SpiClk  out  1  SCK, idle low
- nCs  out  CS_COUNT  active-low chip selects
- Busy  out  1  transfer in progress
- Done  out  1  one-cycle pulse at the end of a transfer
- Timeout  out  1  sticky wait-and-read timeout flag; cleared by Start

Behaviour:
- Reset values: SpiClk=0, SpiDo=1, nCs=all 1, Busy=0, Done=0, Timeout=0, RxWe=0, TxAddr=0, RxAddr=0, FSM=IDLE.
- nCs is registered: nCs[i] = ~(CsAssert && CsSel==i). It is independent of Busy, so /CS stays low between transfers. A CsSel ≥ CS_COUNT asserts nothing.
- FSM states: IDLE, FETCH, SHIFT, STORE, FINISH.
- IDLE:
  - On Start (and not Busy): latch Mode/Len/ClkDiv, set byte counter=0, TxAddr=0, RxAddr=0, clear Timeout, set Busy=1, go to FETCH.
  - Start while Busy is ignored.
- FETCH (1 cycle):
  - TX byte comes from TxData for modes 0/2; it is the constant 0xFF for modes 1/3.
  - Go to SHIFT with SpiDo = bit 7.
- SHIFT, 8 bits MSB first:
  - SCK low for ClkDiv+1 cycles, then rises; sample SpiDi on the rising edge.
  - SCK high for ClkDiv+1 cycles, then falls; shift SpiDo on the falling edge, except after bit 0.
  - One byte takes 16·(ClkDiv+1) cycles. After the 8th falling edge go to STORE.
- STORE (1 cycle):
  - Mode 0: no RX write.
  - Modes 1/2: RxWe=1, RxAddr = byte index.
  - Mode 3 (wait-and-read):
    - While the wait phase is unmatched, a received 0xFF is discarded and the poll counter increments.
    - The first non-0xFF byte is written at RxAddr 0. From then on every byte, including 0xFF, is written.
    - The byte counter counts only written bytes.
  - Exit: if byte counter == Len, or Abort is pending, go to FINISH. Otherwise increment counters and TxAddr, then go to FETCH.
  - The inter-byte gap is exactly 2 Clk cycles (STORE+FETCH) with SCK low.
- Wait timeout: when the poll counter reaches WAIT_LIMIT, set Timeout=1 and go to FINISH. No RX bytes are written.
- FINISH: Done=1 for 1 cycle, Busy=0, SpiDo=1, then IDLE.
- Abort:
  - Latched as pending while Busy; takes effect at the next STORE. The byte in flight completes and its STORE write still occurs.
  - Abort in IDLE is ignored.
  - Done pulses on abort completion.
- Len=BUF_DEPTH-1 transfers the full buffer; the address wraps only after the final byte, which never matters because the transfer stops.
- Reset mid-transfer returns every output to its reset value immediately.

Decomposition:
- Shared package spi_pkg:
  - Mode enum: SPI_MODE_WRITE=0, SPI_MODE_READ=1, SPI_MODE_EXCHANGE=2, SPI_MODE_WAIT_READ=3.
  - FSM state enum.
  - Constant SPI_IDLE_BYTE=8'hFF.
- One sub-module, spi_clk_gen: the divider counter. It takes Clk, Reset, Run and ClkDiv, and outputs SCK plus RisePulse and FallPulse strobes.

Test Plan:
- Exchange, ClkDiv=0, Len=3:
  - Stimulus: TX buffer AB CD EF 12; slave returns FF 3E CA 04.
  - Required: RX = FF 3E CA 04; slave receives AB CD EF 12; Done after 4·16+overhead cycles; SCK period = 2 Clk.
- Wait-and-read, Len=4:
  - Stimulus: slave returns FF FF FF 53 85 F0 FF 21.
  - Required: RX[0..4] = 53 85 F0 FF 21; 8 bytes of 0xFF on MOSI; RxWe pulses 5 times.
- Wait-and-read, Len=0, ClkDiv=7:
  - Stimulus: slave returns six 0xFF then E3.
  - Required: RX[0] = E3; RX[1] unchanged; SCK high time = 8 Clk.
- Wait-and-read timeout, WAIT_LIMIT=16:
  - Stimulus: slave returns all 0xFF.
  - Required: Timeout=1 after 16 bytes; no RxWe; Done pulses once.
- Abort during byte 1 of a 10-byte read:
  - Required: bytes 0 and 1 written, byte 2 never started, Done pulses, Busy falls.
  - Then Start again: the transfer runs normally and Timeout is 0.
- CS and reset:
  - CsSel=1, CsAssert=1 → nCs=2'b01.
  - Reset asserted mid-SHIFT → SpiClk=0, nCs=2'b11, Busy=0 in the same cycle.
  - Start while Busy → ignored; transfer length unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master transfer engine.
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_MODE_WRITE     = 2'd0,
    SPI_MODE_READ      = 2'd1,
    SPI_MODE_EXCHANGE  = 2'd2,
    SPI_MODE_WAIT_READ = 2'd3
  } spi_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_STORE,
    ST_FINISH
  } spi_state_e;

  localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

  function automatic logic mode_sends_tx(input spi_mode_e m);
    return (m == SPI_MODE_WRITE) || (m == SPI_MODE_EXCHANGE);
  endfunction

  function automatic logic mode_reads(input spi_mode_e m);
    return (m == SPI_MODE_READ) || (m == SPI_MODE_EXCHANGE);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK divider: each SCK half-period lasts ClkDiv+1 Clk cycles while Run is high.
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [DIV_W-1:0] ClkDiv,
  output logic             Sck,
  output logic             RisePulse,
  output logic             FallPulse
);

  logic [DIV_W-1:0] cnt;
  logic             half_end;

  assign half_end  = Run && (cnt == ClkDiv);
  assign RisePulse = half_end && !Sck;
  assign FallPulse = half_end && Sck;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
      Sck <= 1'b0;
    end else if (!Run) begin
      cnt <= '0;
      Sck <= 1'b0;
    end else if (half_end) begin
      cnt <= '0;
      Sck <= ~Sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_engine.sv
// SPI mode-0 master transfer engine: byte FSM, buffer port, chip selects, wait-and-read.
module spi_master_engine
  import spi_pkg::*;
#(
  parameter  int CS_COUNT   = 2,
  parameter  int BUF_DEPTH  = 512,
  parameter  int DIV_W      = 8,
  parameter  int WAIT_LIMIT = 4096,
  localparam int AW         = $clog2(BUF_DEPTH),
  localparam int CS_W       = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Abort,
  input  logic [1:0]          Mode,
  input  logic [AW-1:0]       Len,
  input  logic [DIV_W-1:0]    ClkDiv,
  input  logic [CS_W-1:0]     CsSel,
  input  logic                CsAssert,
  output logic [AW-1:0]       TxAddr,
  input  logic [7:0]          TxData,
  output logic                RxWe,
  output logic [AW-1:0]       RxAddr,
  output logic [7:0]          RxData,
  output logic                SpiDo,
  input  logic                SpiDi,
  output logic                SpiClk,
  output logic [CS_COUNT-1:0] nCs,
  output logic                Busy,
  output logic                Done,
  output logic                Timeout
);

  localparam int PW = $clog2(WAIT_LIMIT + 1);

  spi_state_e       state, state_nxt;
  spi_mode_e        mode_q;
  logic [AW-1:0]    len_q, byte_cnt;
  logic [DIV_W-1:0] div_q;
  logic [PW-1:0]    poll_cnt, poll_nxt;
  logic [2:0]       bit_cnt;
  logic             matched, abort_pend;
  logic [6:0]       tx_sh;
  logic [7:0]       rx_sh, tx_byte;
  logic             run, sck_rise, sck_fall;
  logic             rx_keep, discard, poll_timeout, last_byte;

  assign run      = (state == ST_SHIFT);
  assign tx_byte  = mode_sends_tx(mode_q) ? TxData : SPI_IDLE_BYTE;
  assign poll_nxt = poll_cnt + 1'b1;

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .Clk       (Clk),
    .Reset     (Reset),
    .Run       (run),
    .ClkDiv    (div_q),
    .Sck       (SpiClk),
    .RisePulse (sck_rise),
    .FallPulse (sck_fall)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // In wait-and-read, 0xFF is polling filler until the first real byte arrives.
  always_comb begin
    rx_keep   = mode_reads(mode_q);
    discard   = 1'b0;
    if (mode_q == SPI_MODE_WAIT_READ) begin
      rx_keep = matched || (rx_sh != SPI_IDLE_BYTE);
      discard = !rx_keep;
    end
    poll_timeout = discard && (poll_nxt == PW'(WAIT_LIMIT));
    last_byte    = !discard && (byte_cnt == len_q);

    state_nxt = state;
    case (state)
      ST_IDLE:   if (Start) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_SHIFT;
      ST_SHIFT:  if (sck_fall && bit_cnt == 3'd7) state_nxt = ST_STORE;
      ST_STORE:  state_nxt = (poll_timeout || last_byte || abort_pend) ? ST_FINISH : ST_FETCH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mode_q     <= SPI_MODE_WRITE;
      len_q      <= '0;
      div_q      <= '0;
      byte_cnt   <= '0;
      poll_cnt   <= '0;
      bit_cnt    <= '0;
      matched    <= 1'b0;
      abort_pend <= 1'b0;
      TxAddr     <= '0;
      RxAddr     <= '0;
      RxWe       <= 1'b0;
      SpiDo      <= 1'b1;
      nCs        <= '1;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Timeout    <= 1'b0;
    end else begin
      Done <= 1'b0;
      RxWe <= 1'b0;
      for (int i = 0; i < CS_COUNT; i++) nCs[i] <= ~(CsAssert && (CsSel == CS_W'(i)));
      if (Abort && Busy) abort_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (Start) begin
            mode_q     <= spi_mode_e'(Mode);
            len_q      <= Len;
            div_q      <= ClkDiv;
            byte_cnt   <= '0;
            poll_cnt   <= '0;
            bit_cnt    <= '0;
            matched    <= 1'b0;
            abort_pend <= 1'b0;
            TxAddr     <= '0;
            RxAddr     <= '0;
            Timeout    <= 1'b0;
            Busy       <= 1'b1;
          end
        end
        ST_FETCH: begin
          SpiDo   <= tx_byte[7];
          bit_cnt <= '0;
        end
        ST_SHIFT: begin
          if (sck_fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            // The TX buffer has a 1-cycle read, so the next address goes out during STORE.
            if (bit_cnt == 3'd7) TxAddr <= byte_cnt + 1'b1;
            else                 SpiDo  <= tx_sh[6];
          end
        end
        ST_STORE: begin
          if (rx_keep) begin
            RxWe    <= 1'b1;
            RxAddr  <= byte_cnt;
            matched <= 1'b1;
          end
          if (discard)      poll_cnt <= poll_nxt;
          if (poll_timeout) Timeout  <= 1'b1;
          if (state_nxt == ST_FINISH) begin
            Busy       <= 1'b0;
            Done       <= 1'b1;
            SpiDo      <= 1'b1;
            TxAddr     <= '0;
            abort_pend <= 1'b0;
          end else if (!discard) begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Shift registers and RX data carry no reset; they are always loaded before use.
  always_ff @(posedge Clk) begin
    case (state)
      ST_FETCH: tx_sh <= tx_byte[6:0];
      ST_SHIFT: begin
        if (sck_rise) rx_sh <= {rx_sh[6:0], SpiDi};
        if (sck_fall) tx_sh <= {tx_sh[5:0], 1'b0};
      end
      ST_STORE: RxData <= rx_sh;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench for spi_master_engine with TX/RX buffer models and a mode-0 SPI slave.
module tb_spi_master_engine;

  localparam int AW = 9;

  logic          Clk = 1'b0;
  logic          Reset, Start, Abort, CsAssert;
  logic [1:0]    Mode;
  logic [AW-1:0] Len, TxAddr, RxAddr;
  logic [7:0]    ClkDiv, TxData, RxData;
  logic [0:0]    CsSel;
  logic          RxWe, SpiDo, SpiDi, SpiClk, Busy, Done, Timeout;
  logic [1:0]    nCs;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  spi_master_engine #(
    .CS_COUNT(2), .BUF_DEPTH(512), .DIV_W(8), .WAIT_LIMIT(16)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Mode(Mode), .Len(Len),
    .ClkDiv(ClkDiv), .CsSel(CsSel), .CsAssert(CsAssert), .TxAddr(TxAddr), .TxData(TxData),
    .RxWe(RxWe), .RxAddr(RxAddr), .RxData(RxData), .SpiDo(SpiDo), .SpiDi(SpiDi),
    .SpiClk(SpiClk), .nCs(nCs), .Busy(Busy), .Done(Done), .Timeout(Timeout)
  );

  // Buffers: synchronous-read TX, write-strobed RX
  logic [7:0] mem_tx [0:511];
  logic [7:0] mem_rx [0:511];
  int we_cnt;
  always @(posedge Clk) TxData <= mem_tx[TxAddr];
  always @(posedge Clk) if (RxWe === 1'b1) begin
    mem_rx[RxAddr] = RxData;
    we_cnt++;
  end

  // Mode-0 slave: samples MOSI on SCK rise, changes MISO on SCK fall
  logic [7:0] sl_tx [0:31];
  logic [7:0] sl_rx [0:31];
  logic [7:0] sl_cur, sl_sh;
  logic       sl_miso;
  int sl_ti, sl_ri, sl_bit;
  assign SpiDi = sl_miso;
  always @(posedge SpiClk) begin
    sl_sh = {sl_sh[6:0], SpiDo};
    sl_bit++;
  end
  always @(negedge SpiClk) begin
    if (sl_bit >= 8) begin
      if (sl_ri < 32) sl_rx[sl_ri] = sl_sh;
      sl_ri++;
      sl_bit = 0;
      sl_ti++;
      sl_cur = (sl_ti < 32) ? sl_tx[sl_ti] : 8'hFF;
      sl_miso = sl_cur[7];
    end else begin
      sl_miso = sl_cur[7 - sl_bit];
    end
  end

  // SCK shape and Done pulse monitors
  int cyc, last_rise, sck_period, sck_hi_run, sck_hi_len, done_cnt;
  logic sck_prev = 1'b0;
  always @(negedge Clk) begin
    cyc++;
    if (SpiClk && !sck_prev) begin
      sck_period = cyc - last_rise;
      last_rise  = cyc;
    end
    if (SpiClk) sck_hi_run++;
    else if (sck_prev) begin
      sck_hi_len = sck_hi_run;
      sck_hi_run = 0;
    end
    sck_prev = SpiClk;
    if (Done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_init(input logic [63:0] b, input int n);
    for (int i = 0; i < 32; i++) begin
      sl_tx[i] = 8'hFF;
      sl_rx[i] = 8'h00;
    end
    for (int i = 0; i < n; i++) sl_tx[i] = b[63 - 8*i -: 8];
    sl_ti = 0; sl_ri = 0; sl_bit = 0; sl_sh = 8'h00;
    sl_cur = sl_tx[0];
    sl_miso = sl_cur[7];
  endtask

  task automatic clear_rx(input logic [7:0] v);
    for (int i = 0; i < 512; i++) mem_rx[i] = v;
    we_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic start_xfer(input logic [1:0] m, input logic [AW-1:0] l, input logic [7:0] d);
    Mode = m; Len = l; ClkDiv = d; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (Done !== 1'b1 && n < budget) begin
      @(posedge Clk); #1;
      n++;
    end
  endtask

  int n;
  logic [7:0] acc;

  initial begin
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Mode = 2'd0; Len = '0; ClkDiv = 8'd0;
    CsSel = 1'b0; CsAssert = 1'b0;
    for (int i = 0; i < 512; i++) mem_tx[i] = 8'h00;
    clear_rx(8'h00);
    slave_init(64'h0, 0);
    repeat (3) @(posedge Clk); #1;
    check("rst_sck",  {31'd0, SpiClk}, 32'd0);
    check("rst_mosi", {31'd0, SpiDo},  32'd1);
    check("rst_ncs",  {30'd0, nCs},    32'd3);
    check("rst_ctl",  {29'd0, Busy, Done, Timeout}, 32'd0);
    check("rst_rx",   {31'd0, RxWe},   32'd0);
    check("rst_addr", {14'd0, TxAddr, RxAddr}, 32'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Exchange, ClkDiv=0, 4 bytes
    mem_tx[0] = 8'hAB; mem_tx[1] = 8'hCD; mem_tx[2] = 8'hEF; mem_tx[3] = 8'h12;
    slave_init(64'hFF3ECA04_00000000, 4);
    clear_rx(8'h00);
    start_xfer(2'd2, 9'd3, 8'd0);
    check("xchg_busy", {31'd0, Busy}, 32'd1);
    wait_done(200, n);
    check("xchg_cycles", n, 72);
    repeat (3) @(posedge Clk); #1;
    check("xchg_rx",    {mem_rx[0], mem_rx[1], mem_rx[2], mem_rx[3]}, 32'hFF3ECA04);
    check("xchg_mosi",  {sl_rx[0], sl_rx[1], sl_rx[2], sl_rx[3]}, 32'hABCDEF12);
    check("xchg_sckp",  sck_period, 2);
    check("xchg_we",    we_cnt, 4);
    check("xchg_idle",  {30'd0, Busy, SpiDo}, 32'd1);
    check("xchg_done1", done_cnt, 1);

    // Wait-and-read, Len=4
    slave_init(64'hFFFFFF53_85F0FF21, 8);
    clear_rx(8'h00);
    start_xfer(2'd3, 9'd4, 8'd1);
    wait_done(1000, n);
    repeat (3) @(posedge Clk); #1;
    check("wr_rx0_3", {mem_rx[0], mem_rx[1], mem_rx[2], mem_rx[3]}, 32'h5385F0FF);
    check("wr_rx4",   {24'd0, mem_rx[4]}, 32'h21);
    check("wr_we",    we_cnt, 5);
    acc = 8'hFF;
    for (int i = 0; i < 8; i++) acc = acc & sl_rx[i];
    check("wr_mosi_n",  sl_ri, 8);
    check("wr_mosi_ff", {24'd0, acc}, 32'hFF);
    check("wr_timeout", {31'd0, Timeout}, 32'd0);

    // Wait-and-read, Len=0, ClkDiv=7
    slave_init(64'hFFFFFFFF_FFFFE300, 7);
    clear_rx(8'h5A);
    start_xfer(2'd3, 9'd0, 8'd7);
    wait_done(3000, n);
    repeat (3) @(posedge Clk); #1;
    check("wr0_rx0",  {24'd0, mem_rx[0]}, 32'hE3);
    check("wr0_rx1",  {24'd0, mem_rx[1]}, 32'h5A);
    check("wr0_sckh", sck_hi_len, 8);
    check("wr0_we",   we_cnt, 1);

    // Wait-and-read timeout after 16 polled bytes
    slave_init(64'h0, 0);
    clear_rx(8'h00);
    start_xfer(2'd3, 9'd3, 8'd0);
    wait_done(1000, n);
    check("to_cycles", n, 16 * 18);
    check("to_flag",   {31'd0, Timeout}, 32'd1);
    repeat (5) @(posedge Clk); #1;
    check("to_we",     we_cnt, 0);
    check("to_done",   done_cnt, 1);
    check("to_sticky", {31'd0, Timeout}, 32'd1);

    // Abort during byte 1 of a 10-byte read
    slave_init(64'h11223344_55667788, 8);
    clear_rx(8'h00);
    start_xfer(2'd1, 9'd9, 8'd1);
    check("ab_to_clr", {31'd0, Timeout}, 32'd0);
    repeat (49) @(posedge Clk); #1;
    Abort = 1'b1;
    @(posedge Clk); #1;
    Abort = 1'b0;
    wait_done(1000, n);
    repeat (5) @(posedge Clk); #1;
    check("ab_rx",    {mem_rx[0], mem_rx[1], mem_rx[2], 8'h00}, 32'h11220000);
    check("ab_we",    we_cnt, 2);
    check("ab_bytes", sl_ri, 2);
    check("ab_done",  done_cnt, 1);
    check("ab_busy",  {31'd0, Busy}, 32'd0);

    // Normal read after abort
    slave_init(64'h77880000_00000000, 2);
    clear_rx(8'h00);
    start_xfer(2'd1, 9'd1, 8'd0);
    wait_done(200, n);
    check("re_cycles", n, 36);
    repeat (3) @(posedge Clk); #1;
    check("re_rx",      {16'd0, mem_rx[0], mem_rx[1]}, 32'h7788);
    check("re_timeout", {31'd0, Timeout}, 32'd0);

    // Chip selects
    CsSel = 1'b1; CsAssert = 1'b1;
    @(posedge Clk); #1;
    check("cs_sel1", {30'd0, nCs}, 32'h1);
    CsSel = 1'b0;
    @(posedge Clk); #1;
    check("cs_sel0", {30'd0, nCs}, 32'h2);

    // Start while busy is ignored
    mem_tx[0] = 8'h5A; mem_tx[1] = 8'hA5;
    slave_init(64'h0, 0);
    clear_rx(8'h00);
    start_xfer(2'd0, 9'd1, 8'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin Start = 1'b1; Len = 9'd7; end
      if (i == 5) Start = 1'b0;
      @(posedge Clk); #1;
    end
    wait_done(200, n);
    check("sb_cycles", n + 10, 36);
    repeat (3) @(posedge Clk); #1;
    check("sb_bytes", sl_ri, 2);
    check("sb_mosi",  {16'd0, sl_rx[0], sl_rx[1]}, 32'h5AA5);
    check("sb_we",    we_cnt, 0);

    // Reset while SCK is high mid-byte
    start_xfer(2'd2, 9'd3, 8'd3);
    repeat (6) @(posedge Clk);
    #3;
    check("rs_pre_sck", {31'd0, SpiClk}, 32'd1);
    Reset = 1'b1;
    #1;
    check("rs_sck",  {31'd0, SpiClk}, 32'd0);
    check("rs_ncs",  {30'd0, nCs}, 32'h3);
    check("rs_busy", {31'd0, Busy}, 32'd0);
    check("rs_mosi", {31'd0, SpiDo}, 32'd1);
    #10;
    Reset = 1'b0;
    repeat (2) @(posedge Clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
